// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
// -----------------------------------------------------------------------------
// Shared types for the single-port RAM sequencer/arbiter:
//   arb_state_e  : sequencer state (clearing the RAM, or arbitrating)
//   arb_gnt_e    : grant / return-path tag (which port owns a RAM access)
//   starve_cnt_w : width of the starvation counter for a given limit
// -----------------------------------------------------------------------------
package ram_arb_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VID  = 2'd1,
    GNT_CPU  = 2'd2
  } arb_gnt_e;

  // Bits needed to count 0..limit inclusive; never narrower than one bit.
  function automatic int starve_cnt_w(input int limit);
    if (limit < 1) begin
      return 1;
    end else begin
      return $clog2(limit + 1);
    end
  endfunction

endpackage

// File: rtl/ram_arb_starve.sv
// ram_arb_starve
// -----------------------------------------------------------------------------
// Saturating starvation counter for the CPU port. Counts arbitration edges the
// CPU was eligible for but lost; once the count reaches STARVE_LIMIT the force
// output goes high so the CPU wins the next edge it is eligible.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   srst       in   synchronous clear (held while the RAM is being cleared)
//   grant_cpu  in   CPU granted this edge: counter returns to zero
//   lose_cpu   in   CPU eligible but not granted this edge: count up
//   force_cpu  out  counter has saturated at STARVE_LIMIT
// -----------------------------------------------------------------------------
module ram_arb_starve
  import ram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic srst,
  input  logic grant_cpu,
  input  logic lose_cpu,
  output logic force_cpu
);

  localparam int CNT_W = starve_cnt_w(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear on grant or soft reset, otherwise saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (srst || grant_cpu) begin
      cnt_d = '0;
    end else if (lose_cpu && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_cpu = (cnt_q == LIMIT_C);

endmodule

// File: rtl/ram_1h_arbiter.sv
// ram_1h_arbiter
// -----------------------------------------------------------------------------
// Sequencer and two-port arbiter in front of a single-port block RAM with a
// registered read port and write-through. After reset every location is
// written with CLEAR_VALUE; afterwards the port is shared between a video read
// port (fixed priority) and a CPU read/write port protected by a starvation
// guard.
//
// Response path: a request sampled at edge E0 is driven onto ram_* at E0, the
// RAM captures it at E1, and ram_q is registered into vid_q / cpu_rdata at E2,
// so vid_valid / cpu_ack are high for the cycle after E2. A two-stage tag
// pipeline remembers which port owns each returning ram_q.
//
// Ports:
//   clock, reset_n           clock and asynchronous active-low reset
//   busy                     high while the RAM is being cleared
//   vid_req/vid_addr         one-cycle video read request
//   vid_valid/vid_q          one-cycle video read response
//   vid_miss                 pulse: a video request was dropped for the CPU
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  CPU request, held until cpu_ack
//   cpu_ack/cpu_rdata        one-cycle CPU completion, read or written data
//   ram_clken/ram_wren/ram_addr/ram_data  RAM controls (all registered)
//   ram_q                    RAM registered read data
// -----------------------------------------------------------------------------
module ram_1h_arbiter
  import ram_arb_pkg::*;
#(
  parameter int                ADDR_W       = 11,
  parameter int                DATA_W       = 8,
  parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0,
  parameter int                STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              busy,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_q,
  output logic              vid_miss,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ram_clken,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q
);

  // Sequencer state and clear progress.
  arb_state_e        state_q,     state_d;
  logic              busy_q,      busy_d;
  logic [ADDR_W-1:0] clr_cnt_q,   clr_cnt_d;
  logic              clr_last_q,  clr_last_d;

  // Issue stage (drives the RAM).
  logic              ram_clken_q, ram_clken_d;
  logic              ram_wren_q,  ram_wren_d;
  logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
  logic [DATA_W-1:0] ram_data_q,  ram_data_d;

  // Ownership tags: stage 0 rides with ram_*, stage 1 with ram_q.
  arb_gnt_e          tag0_q,      tag0_d;
  arb_gnt_e          tag1_q,      tag1_d;

  // Response stage.
  logic              vid_valid_q, vid_valid_d;
  logic [DATA_W-1:0] vid_data_q,  vid_data_d;
  logic              vid_miss_q,  vid_miss_d;
  logic              cpu_ack_q,   cpu_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

  // Arbitration results for the current edge.
  arb_gnt_e          gnt;
  logic              vid_drop;
  logic              cpu_in_flight;
  logic              cpu_eligible;
  logic              starve_force;

  // A CPU operation blocks a new CPU grant until its ack edge has passed.
  assign cpu_in_flight = (tag0_q == GNT_CPU) || (tag1_q == GNT_CPU);
  assign cpu_eligible  = (state_q == ST_RUN) && cpu_req && !cpu_in_flight;

  ram_arb_starve #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clock     (clock),
    .reset_n   (reset_n),
    .srst      (state_q != ST_RUN),
    .grant_cpu (gnt == GNT_CPU),
    .lose_cpu  (cpu_eligible && (gnt != GNT_CPU)),
    .force_cpu (starve_force)
  );

  // Grant decision: video first, unless the starving CPU is forced through.
  always_comb begin
    gnt      = GNT_NONE;
    vid_drop = 1'b0;
    if (state_q == ST_RUN) begin
      if (cpu_eligible && (starve_force || !vid_req)) begin
        gnt      = GNT_CPU;
        vid_drop = vid_req;
      end else if (vid_req) begin
        gnt = GNT_VID;
      end else begin
        gnt = GNT_NONE;
      end
    end else begin
      gnt = GNT_NONE;
    end
  end

  // Next state, clear sequencing and the RAM issue stage.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    clr_cnt_d   = clr_cnt_q;
    clr_last_d  = clr_last_q;
    ram_clken_d = 1'b0;
    ram_wren_d  = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;
    tag0_d      = GNT_NONE;
    vid_miss_d  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        if (clr_last_q) begin
          // Top address already written: spend this edge entering RUN.
          state_d    = ST_RUN;
          busy_d     = 1'b0;
          clr_last_d = 1'b0;
          clr_cnt_d  = '0;
        end else begin
          ram_clken_d = 1'b1;
          ram_wren_d  = 1'b1;
          ram_addr_d  = clr_cnt_q;
          ram_data_d  = CLEAR_VALUE;
          clr_cnt_d   = clr_cnt_q + ADDR_W'(1);
          clr_last_d  = (clr_cnt_q == {ADDR_W{1'b1}});
        end
      end
      ST_RUN: begin
        tag0_d     = gnt;
        vid_miss_d = vid_drop;
        case (gnt)
          GNT_CPU: begin
            ram_clken_d = 1'b1;
            ram_wren_d  = cpu_we;
            ram_addr_d  = cpu_addr;
            ram_data_d  = cpu_wdata;
          end
          GNT_VID: begin
            ram_clken_d = 1'b1;
            ram_wren_d  = 1'b0;
            ram_addr_d  = vid_addr;
          end
          default: begin
            ram_clken_d = 1'b0;
            ram_wren_d  = 1'b0;
          end
        endcase
      end
      default: begin
        state_d    = ST_CLEAR;
        busy_d     = 1'b1;
        clr_cnt_d  = '0;
        clr_last_d = 1'b0;
      end
    endcase
  end

  // Return path: route ram_q to the port named by the second tag stage.
  always_comb begin
    tag1_d      = tag0_q;
    vid_valid_d = (tag1_q == GNT_VID);
    cpu_ack_d   = (tag1_q == GNT_CPU);
    if (tag1_q == GNT_VID) begin
      vid_data_d = ram_q;
    end else begin
      vid_data_d = vid_data_q;
    end
    if (tag1_q == GNT_CPU) begin
      cpu_rdata_d = ram_q;
    end else begin
      cpu_rdata_d = cpu_rdata_q;
    end
  end

  // All state and output registers; reset abandons anything in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_CLEAR;
      busy_q      <= 1'b1;
      clr_cnt_q   <= '0;
      clr_last_q  <= 1'b0;
      ram_clken_q <= 1'b0;
      ram_wren_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      tag0_q      <= GNT_NONE;
      tag1_q      <= GNT_NONE;
      vid_valid_q <= 1'b0;
      vid_data_q  <= '0;
      vid_miss_q  <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_last_q  <= clr_last_d;
      ram_clken_q <= ram_clken_d;
      ram_wren_q  <= ram_wren_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      tag0_q      <= tag0_d;
      tag1_q      <= tag1_d;
      vid_valid_q <= vid_valid_d;
      vid_data_q  <= vid_data_d;
      vid_miss_q  <= vid_miss_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  assign busy      = busy_q;
  assign ram_clken = ram_clken_q;
  assign ram_wren  = ram_wren_q;
  assign ram_addr  = ram_addr_q;
  assign ram_data  = ram_data_q;
  assign vid_valid = vid_valid_q;
  assign vid_q     = vid_data_q;
  assign vid_miss  = vid_miss_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_ram_1h_arbiter.sv
// Testbench for ram_1h_arbiter: behavioural single-port RAM, directed stimulus,
// expected responses queued at issue time and checked by an independent monitor.
module tb_ram_1h_arbiter;

  localparam int         ADDR_W       = 11;
  localparam int         DATA_W       = 8;
  localparam int         STARVE_LIMIT = 4;
  localparam int         DEPTH        = 1 << ADDR_W;
  localparam logic [7:0] CLEAR_VALUE  = 8'h00;

  logic              clock   = 1'b0;
  logic              reset_n = 1'b0;
  logic              busy;
  logic              vid_req   = 1'b0;
  logic [ADDR_W-1:0] vid_addr  = '0;
  logic              vid_valid;
  logic [DATA_W-1:0] vid_q;
  logic              vid_miss;
  logic              cpu_req   = 1'b0;
  logic              cpu_we    = 1'b0;
  logic [ADDR_W-1:0] cpu_addr  = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              ram_clken;
  logic              ram_wren;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] ram_q = '0;

  ram_1h_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .CLEAR_VALUE  (CLEAR_VALUE),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .busy      (busy),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_valid (vid_valid),
    .vid_q     (vid_q),
    .vid_miss  (vid_miss),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .ram_clken (ram_clken),
    .ram_wren  (ram_wren),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_q     (ram_q)
  );

  always #5 clock = ~clock;

  // Single-port RAM, registered read, write-through.
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  always @(posedge clock) begin
    if (ram_clken) begin
      if (ram_wren) begin
        mem[ram_addr] <= ram_data;
        ram_q         <= ram_data;
      end else begin
        ram_q <= mem[ram_addr];
      end
    end
  end

  // Number of rising edges so far; stable when sampled on the falling edge.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t vid_exp[$];
  exp_t cpu_exp[$];
  int   miss_exp[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void push_vid(input logic [7:0] d, input int due);
    exp_t e;
    e.data = d;
    e.due  = due;
    vid_exp.push_back(e);
  endfunction

  function automatic void push_cpu(input logic [7:0] d, input int due);
    exp_t e;
    e.data = d;
    e.due  = due;
    cpu_exp.push_back(e);
  endfunction

  // Monitor: every response pulse must match the oldest expectation, on time.
  exp_t me;
  always @(negedge clock) begin
    if (vid_valid) begin
      if (vid_exp.size() == 0) begin
        check("vid_valid_unexpected", 32'(vid_valid), 32'd0);
      end else begin
        me = vid_exp.pop_front();
        check("vid_q", 32'(vid_q), 32'(me.data));
        check("vid_latency", 32'(cyc), 32'(me.due));
      end
    end else if (vid_exp.size() > 0 && cyc > vid_exp[0].due) begin
      me = vid_exp.pop_front();
      check("vid_timeout", 32'(cyc), 32'(me.due));
    end

    if (cpu_ack) begin
      if (cpu_exp.size() == 0) begin
        check("cpu_ack_unexpected", 32'(cpu_ack), 32'd0);
      end else begin
        me = cpu_exp.pop_front();
        check("cpu_rdata", 32'(cpu_rdata), 32'(me.data));
        check("cpu_latency", 32'(cyc), 32'(me.due));
      end
    end else if (cpu_exp.size() > 0 && cyc > cpu_exp[0].due) begin
      me = cpu_exp.pop_front();
      check("cpu_timeout", 32'(cyc), 32'(me.due));
    end

    if (vid_miss) begin
      if (miss_exp.size() == 0) begin
        check("vid_miss_unexpected", 32'(vid_miss), 32'd0);
      end else begin
        check("vid_miss_cycle", 32'(cyc), 32'(miss_exp.pop_front()));
      end
    end else if (miss_exp.size() > 0 && cyc > miss_exp[0]) begin
      check("vid_miss_timeout", 32'(cyc), 32'(miss_exp.pop_front()));
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_ram"}, 32'({ram_clken, ram_wren, ram_addr, ram_data}), 32'd0);
    check({tag, "_pulses"}, 32'({vid_valid, vid_miss, cpu_ack}), 32'd0);
    check({tag, "_vid_q"}, 32'(vid_q), 32'd0);
    check({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
  endtask

  // Called on the falling edge where reset_n was just released.
  task automatic check_clear();
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      a = ADDR_W'(i);
      if (i < 64) begin
        vid_req   = 1'b1;
        vid_addr  = a;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 11'h7FF;
        cpu_wdata = 8'h5A;
      end else begin
        vid_req = 1'b0;
        cpu_req = 1'b0;
      end
      check("clear_write", 32'({ram_clken, ram_wren, ram_addr, ram_data}),
            32'({2'b11, a, CLEAR_VALUE}));
      check("clear_busy", 32'(busy), 32'd1);
    end
    @(negedge clock);
    check("busy_after_clear", 32'(busy), 32'd0);
    check("clken_after_clear", 32'(ram_clken), 32'd0);
  endtask

  // Called on a falling edge; the request is sampled on the next rising edge.
  task automatic cpu_op(input logic we, input logic [ADDR_W-1:0] a,
                        input logic [7:0] wd, input logic [7:0] exp_d);
    int k;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = wd;
    push_cpu(exp_d, cyc + 3);
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!cpu_ack && k < 20);
    if (!cpu_ack) check("cpu_op_no_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;
    @(negedge clock);
  endtask

  int c0;

  initial begin
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    reset_n = 1'b1;
    check_clear();

    // First access after clear; issued on the first edge a grant is possible.
    cpu_op(1'b0, 11'd9, 8'h00, 8'h00);

    // Write then read back.
    cpu_op(1'b1, 11'h123, 8'hA5, 8'hA5);
    cpu_op(1'b0, 11'h123, 8'h00, 8'hA5);

    // Preload 0..4 with their own address, then stream five video reads.
    for (int i = 0; i < 5; i++) cpu_op(1'b1, ADDR_W'(i), 8'(i), 8'(i));
    for (int i = 0; i < 5; i++) begin
      vid_req  = 1'b1;
      vid_addr = ADDR_W'(i);
      push_vid(8'(i), cyc + 3);
      @(negedge clock);
    end
    vid_req = 1'b0;
    repeat (4) @(negedge clock);

    // Starvation: video held high; CPU loses four edges, wins the fifth.
    c0        = cyc;
    vid_req   = 1'b1;
    vid_addr  = 11'd3;
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 11'h123;
    push_cpu(8'hA5, c0 + 7);
    miss_exp.push_back(c0 + 5);
    for (int k = 1; k <= 7; k++) begin
      if (k != 5) push_vid(8'h03, c0 + k + 2);
    end
    repeat (5) @(negedge clock);
    check("starve_issue", 32'({ram_clken, ram_wren, ram_addr}), 32'({2'b10, 11'h123}));
    repeat (2) @(negedge clock);
    check("starve_ack", 32'(cpu_ack), 32'd1);
    vid_req = 1'b0;
    cpu_req = 1'b0;
    repeat (4) @(negedge clock);

    // Held request: second transaction on the edge after the ack cycle.
    c0       = cyc;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 11'd4;
    push_cpu(8'h04, c0 + 3);
    push_cpu(8'h04, c0 + 6);
    repeat (2) @(negedge clock);
    check("held_gap_clken", 32'(ram_clken), 32'd0);
    @(negedge clock);
    check("held_first_ack", 32'(cpu_ack), 32'd1);
    @(negedge clock);
    check("held_reissue", 32'({ram_clken, ram_wren, ram_addr}), 32'({2'b10, 11'd4}));
    repeat (2) @(negedge clock);
    check("held_second_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;
    @(negedge clock);
    check("held_no_third", 32'(ram_clken), 32'd0);
    repeat (2) @(negedge clock);

    // Reset between E0 and E2 of a CPU read: no ack, clear restarts at 0.
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 11'h123;
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    cpu_req = 1'b0;
    @(negedge clock);
    check_reset_values("midreset");
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    check_clear();
    cpu_op(1'b0, 11'h123, 8'h00, CLEAR_VALUE);

    repeat (5) @(negedge clock);
    check("vid_exp_left", 32'(vid_exp.size()), 32'd0);
    check("cpu_exp_left", 32'(cpu_exp.size()), 32'd0);
    check("miss_exp_left", 32'(miss_exp.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
